// File: rtl/jtdd2_subctl.sv
// Main-CPU-side controller for the DD2 sub CPU: sub reset stretch, bus-request
// handshake with timeout, NMI pulse generation and the sub-to-main IRQ latch.
module jtdd2_subctl #(
    parameter int unsigned NMI_W   = 4,
    parameter int unsigned RST_W   = 16,
    parameter int unsigned HALT_TO = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_cen,
    input  logic       main_wrn,
    input  logic [7:0] main_dout,
    input  logic       ctl_cs,
    input  logic       irqack_cs,
    input  logic       com_cs,
    input  logic       mcu_ban,
    input  logic       mcu_irqmain,
    output logic       mcu_rstb,
    output logic       mcu_halt,
    output logic       mcu_nmi_set,
    output logic       main_irq_n,
    output logic       main_wait,
    output logic [7:0] status_dout
);

    typedef enum logic [1:0] {StRun, StReq, StHeld, StRel} state_e;

    localparam logic [3:0] NmiLoad  = 4'(NMI_W);
    localparam logic [7:0] RstLoad  = 8'(RST_W);
    localparam logic [9:0] TimerMax = 10'(HALT_TO);

    logic       ctl_wr, irq_ack;
    logic       halt_req_q, halt_req_d, sub_run_q, sub_run_d;
    logic [3:0] nmi_cnt_q, nmi_cnt_d;
    logic       nmi_q;
    logic [7:0] rst_cnt_q, rst_cnt_d;
    logic       rstb_q, rstb_d;
    logic       ban_s_q, ban_q, ban_d;
    state_e     state_q;
    logic       halt_q;
    logic [9:0] timer_q;
    logic       timeout_q;
    logic       irq_s_q, irq_pend_q, irq_pend_d, irq_n_q;
    logic       unused_dout;

    assign ctl_wr      = main_cen & ctl_cs & ~main_wrn;
    assign irq_ack     = main_cen & irqack_cs & ~main_wrn;
    assign unused_dout = ^main_dout[7:3];

    // Control register fields take effect at the write edge
    always_comb begin
        halt_req_d = halt_req_q;
        sub_run_d  = sub_run_q;
        if (ctl_wr) begin
            halt_req_d = main_dout[0];
            sub_run_d  = main_dout[2];
        end
    end

    // NMI pulse: every trigger reloads the full width
    always_comb begin
        nmi_cnt_d = nmi_cnt_q;
        if (ctl_wr && main_dout[1]) begin
            nmi_cnt_d = NmiLoad;
        end else if (nmi_cnt_q != 4'd0) begin
            nmi_cnt_d = nmi_cnt_q - 4'd1;
        end
    end

    // Sub reset stretch: only a 0->1 sub_run transition starts the count
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        rstb_d    = rstb_q;
        if (ctl_wr && !main_dout[2]) begin
            rst_cnt_d = 8'd0;
            rstb_d    = 1'b0;
        end else if (ctl_wr && !sub_run_q) begin
            rst_cnt_d = RstLoad;
            rstb_d    = 1'b0;
        end else if (rst_cnt_q != 8'd0) begin
            rst_cnt_d = rst_cnt_q - 8'd1;
            rstb_d    = (rst_cnt_q == 8'd1);
        end
    end

    // Bus-ack is only believed once it has been stable for two edges
    assign ban_d = (mcu_ban == ban_s_q) ? mcu_ban : ban_q;

    // A rising edge of the sub strobe beats a simultaneous acknowledge
    always_comb begin
        irq_pend_d = irq_pend_q;
        if (mcu_irqmain && !irq_s_q) begin
            irq_pend_d = 1'b1;
        end else if (irq_ack) begin
            irq_pend_d = 1'b0;
        end
    end

    // Control, NMI, reset-stretch, ban filter and IRQ state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_req_q <= 1'b0;
            sub_run_q  <= 1'b0;
            nmi_cnt_q  <= 4'd0;
            nmi_q      <= 1'b0;
            rst_cnt_q  <= 8'd0;
            rstb_q     <= 1'b0;
            ban_s_q    <= 1'b1;
            ban_q      <= 1'b1;
            irq_s_q    <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_n_q    <= 1'b1;
        end else begin
            halt_req_q <= halt_req_d;
            sub_run_q  <= sub_run_d;
            nmi_cnt_q  <= nmi_cnt_d;
            nmi_q      <= (nmi_cnt_d != 4'd0);
            rst_cnt_q  <= rst_cnt_d;
            rstb_q     <= rstb_d;
            ban_s_q    <= mcu_ban;
            ban_q      <= ban_d;
            irq_s_q    <= mcu_irqmain;
            irq_pend_q <= irq_pend_d;
            irq_n_q    <= ~irq_pend_d;
        end
    end

    // Halt handshake FSM with request timer and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRun;
            halt_q    <= 1'b0;
            timer_q   <= 10'd0;
            timeout_q <= 1'b0;
        end else begin
            if (ctl_wr) timeout_q <= 1'b0;
            timer_q <= 10'd0;
            case (state_q)
                StRun: begin
                    if (halt_req_d) begin
                        state_q <= StReq;
                        halt_q  <= 1'b1;
                    end
                end
                StReq: begin
                    if (!ban_d) begin
                        state_q <= StHeld;
                    end else if (!halt_req_d) begin
                        state_q <= StRun;
                        halt_q  <= 1'b0;
                    end else begin
                        // Timer saturates so the flag sets only once per request
                        timer_q <= (timer_q == TimerMax) ? timer_q : timer_q + 10'd1;
                        if (timer_q == TimerMax - 10'd1) timeout_q <= 1'b1;
                    end
                end
                StHeld: begin
                    if (!halt_req_d) begin
                        state_q <= StRel;
                        halt_q  <= 1'b0;
                    end else if (ban_d) begin
                        state_q <= StReq;
                    end
                end
                StRel: begin
                    if (ban_d) begin
                        state_q <= StRun;
                    end else if (halt_req_d) begin
                        state_q <= StReq;
                        halt_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StRun;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mcu_rstb    = rstb_q;
    assign mcu_halt    = halt_q;
    assign mcu_nmi_set = nmi_q;
    assign main_irq_n  = irq_n_q;
    // Stall shared-RAM access only while a halt is requested but not yet granted
    assign main_wait   = com_cs & halt_req_q & (state_q != StHeld);
    assign status_dout = {4'b0000, timeout_q, irq_pend_q, (state_q == StHeld), rstb_q};

endmodule
